// File: rtl/alu_pkg.sv
// Shared definitions for the RK16 ALU and the alu_seq multi-cycle sequencer.
// Holds the 4-bit ALU op codes, the 3-bit sequencer request ops and the counter width.
// Optional multiply support in alu_seq is selected by the ALU_SEQ_MUL_EN macro.
package alu_pkg;

  // RK16 ALU operation select codes
  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_NOT     = 4'b0001,
    ALU_L_SFT   = 4'b0010,
    ALU_L_ROT   = 4'b0011,
    ALU_AND     = 4'b0100,
    ALU_XOR     = 4'b0101,
    ALU_OR      = 4'b0110,
    ALU_SUB     = 4'b0111,
    ALU_EQ      = 4'b1000,
    ALU_NEQ     = 4'b1001,
    ALU_LT      = 4'b1010,
    ALU_R_SFT_U = 4'b1100,
    ALU_R_SFT_S = 4'b1101,
    ALU_R_ROT   = 4'b1110
  } alu_sel_e;

  // Sequencer request ops; 110/111 are reserved
  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100,
    OP_MUL = 3'b101
  } seq_op_e;

  localparam int SEQ_CNT_W = 5;

  // Single-bit ALU step used to build each multi-bit shift/rotate
  function automatic alu_sel_e shift_sel(input seq_op_e op);
    case (op)
      OP_SLL:  return ALU_L_SFT;
      OP_SRL:  return ALU_R_SFT_U;
      OP_SRA:  return ALU_R_SFT_S;
      OP_ROL:  return ALU_L_ROT;
      OP_ROR:  return ALU_R_ROT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Sequencer driving the shared RK16 ALU: multi-bit shifts/rotates and optional shift-add MUL.
// Latency: 1+N cycles for shifts (N = count), 1+k for MUL, 1 for zero/reserved cases.
// Backpressure: result held in DONE until res_ready; no accept in the handshake cycle.
// Macro ALU_SEQ_MUL_EN enables the multiply; otherwise op 101 behaves as a reserved op.
import alu_pkg::*;

module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [3:0]  alu_sel,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state, state_nxt;
  seq_op_e              op, op_nxt;
  logic [15:0]          work, work_nxt;
  logic [SEQ_CNT_W-1:0] cnt, cnt_nxt;

`ifdef ALU_SEQ_MUL_EN
  logic [15:0]          mcand, mcand_nxt;
  logic [15:0]          q, q_nxt;
`else
  // Upper count bits only matter to the multiplier
  logic                 unused_req_b;
  assign unused_req_b = ^req_b[15:4];
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op    <= OP_SLL;
      work  <= '0;
      cnt   <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand <= '0;
      q     <= '0;
`endif
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      work  <= work_nxt;
      cnt   <= cnt_nxt;
`ifdef ALU_SEQ_MUL_EN
      mcand <= mcand_nxt;
      q     <= q_nxt;
`endif
    end
  end

  // Next-state and datapath update: one ALU step per RUN cycle
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    work_nxt  = work;
    cnt_nxt   = cnt;
`ifdef ALU_SEQ_MUL_EN
    mcand_nxt = mcand;
    q_nxt     = q;
`endif
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          op_nxt = seq_op_e'(req_op);
          case (seq_op_e'(req_op))
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
              work_nxt  = req_a;
              cnt_nxt   = {1'b0, req_b[3:0]};
              state_nxt = (req_b[3:0] == 4'd0) ? S_DONE : S_RUN;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              work_nxt  = '0;
              mcand_nxt = req_a;
              q_nxt     = req_b;
              cnt_nxt   = 5'd16;
              state_nxt = (req_b == 16'd0) ? S_DONE : S_RUN;
            end
`endif
            default: begin
              work_nxt  = req_a;
              state_nxt = S_DONE;
            end
          endcase
        end
      end
      S_RUN: begin
        cnt_nxt = cnt - 5'd1;
`ifdef ALU_SEQ_MUL_EN
        if (op == OP_MUL) begin
          if (q[0]) work_nxt = alu_out;
          mcand_nxt = {mcand[14:0], 1'b0};
          q_nxt     = {1'b0, q[15:1]};
          // No multiplier bits left above this one means the product is complete
          if ((q[15:1] == 15'd0) || (cnt == 5'd1)) state_nxt = S_DONE;
        end else begin
          work_nxt = alu_out;
          if (cnt == 5'd1) state_nxt = S_DONE;
        end
`else
        work_nxt = alu_out;
        if (cnt == 5'd1) state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs and ALU drive, decoded from the current state
  always_comb begin
    req_ready = (state == S_IDLE);
    res_valid = (state == S_DONE);
    res_data  = (state == S_DONE) ? work : 16'd0;
    alu_sel   = ALU_ADD;
    alu_a     = '0;
    alu_b     = '0;
    if (state == S_RUN) begin
      alu_a = work;
`ifdef ALU_SEQ_MUL_EN
      if (op == OP_MUL) begin
        alu_sel = ALU_ADD;
        alu_b   = mcand;
      end else begin
        alu_sel = shift_sel(op);
      end
`else
      alu_sel = shift_sel(op);
`endif
    end
  end

endmodule
